x25519_input_loader: RTL
========================

Name: x25519_input_loader

Overview:
- Upstream feeder for X25519_MainLoop.
- Accepts a byte-serial RFC 7748 request: 32 scalar bytes, then 32 u-coordinate bytes, both little-endian.
- Clamps the scalar, masks the u-coordinate and reduces it mod p = 2^255-19.
- Presents the 256-bit `e` and `work_in` words to the main loop with a one-cycle `en` pulse. Holds them stable until the main loop reports completion.

Parameters:
- CLAMP, 1, 1 = apply RFC 7748 scalar clamping; 0 = pass scalar through unmodified.
- REDUCE_U, 1, 1 = subtract p from the masked u-coordinate when it is >= p; 0 = mask only.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din_valid  input  1  byte-stream valid.
- din_ready  output  1  byte-stream ready; a byte is accepted on an edge where din_valid && din_ready.
- din  input  8  data byte.
- din_last  input  1  marks the final byte of a request; qualified by din_valid.
- loop_done  input  1  one-cycle pulse from the main loop: computation finished, operands may be released.
- en  output  1  one-cycle start pulse to the main loop.
- e  output  256  clamped scalar.
- work_in  output  256  masked/reduced u-coordinate.
- busy  output  1  high from the first accepted byte until loop_done is consumed.
- frame_err  output  1  one-cycle pulse on a framing error.

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - State = LOAD_E, byte counter = 0, shift registers = 0.
  - en = 0, e = 0, work_in = 0, busy = 0, frame_err = 0.
  - din_ready = 1 in the first cycle after reset release.
- States: LOAD_E, LOAD_U, FIRE, WAIT_DONE.
- din_ready is 1 in LOAD_E and LOAD_U only. It is a registered/state-decoded signal and does not depend on din_valid.
- 6-bit byte counter `cnt` increments on each accepted byte.
  - Byte i (0..31) goes to scalar bits [8i+7:8i].
  - Byte 32+i goes to u bits [8i+7:8i].
- LOAD_E: accepting byte 31 moves to LOAD_U.
- LOAD_U: accepting byte 63 with din_last = 1 moves to FIRE.
- Framing errors:
  - din_last = 1 on any accepted byte other than byte 63, or din_last = 0 on byte 63.
  - Response: frame_err pulses on the next cycle, cnt clears, state returns to LOAD_E, partial data is discarded.
  - e, work_in and en are untouched.
- busy rises on the edge accepting byte 0. It falls when a frame error returns the block to LOAD_E.
- FIRE (exactly one cycle), on its closing edge:
  - e <= CLAMP ? {1'b0, 1'b1, s[253:3], 3'b000} : s.
  - work_in <= reduce({1'b0, u[254:0]}), where reduce(x) = (REDUCE_U && x >= p) ? x - p : x. One 255-bit compare/subtract, combinational from the u shift register.
  - en <= 1; state <= WAIT_DONE.
- Latency:
  - Last byte accepted on edge k.
  - e, work_in and en are all valid after edge k+1.
  - en returns to 0 after edge k+2. en is never high for more than one cycle.
- WAIT_DONE:
  - din_ready = 0; e and work_in held constant.
  - loop_done = 1 moves to LOAD_E, clears cnt and drops busy.
  - din_ready is 1 in the next cycle. e and work_in keep their last values (not cleared).
- loop_done in any state other than WAIT_DONE is ignored. This includes the FIRE cycle and the cycle en is high.
- din_valid with din_ready = 0 is ignored; no byte is consumed.
- Reset mid-frame or during WAIT_DONE: immediate return to reset values; no en pulse is emitted.
- The subtraction uses 256-bit arithmetic. The result is always < p, so bit 255 of work_in is always 0 when REDUCE_U = 1.

Test Plan:
- Nominal:
  - Stimulus: 64 back-to-back bytes encoding scalar 256'h5c21740e549bcdab5e580525a3310d66c9332e76e71b547ce3f2ba294a516960 and u 256'h873d418211b4c6b2d4e9175d5a58b7329a9f635a8de8f8c246fbabcdecff73c6, din_last on byte 63.
  - Required: en = 1 for exactly one cycle, 2 cycles after the last byte edge.
  - Required: e = 5c21...6960 (clamping leaves it unchanged).
  - Required: work_in = 073d418211b4c6b2d4e9175d5a58b7329a9f635a8de8f8c246fbabcdecff73c6.
- Clamp and reduce:
  - Stimulus: all 64 bytes = 0xFF.
  - Required: e = 7FFF...FFF8 (256 bits) and work_in = 256'h12.
- Backpressure:
  - Stimulus: a second frame presented immediately after the first.
  - Required: din_ready stays 0 and no bytes are consumed until loop_done is pulsed; the second frame is then accepted intact and en fires again.
  - Required: a loop_done pulse injected during LOAD_U has no effect.
- Framing:
  - Stimulus: din_last on byte 40.
  - Required: one frame_err pulse, busy drops, no en, and the previous e/work_in are unchanged.
  - Stimulus: a 64-byte frame without din_last.
  - Required: frame_err pulses after byte 63.
- Random valid gaps:
  - Stimulus: din_valid toggled pseudo-randomly during the nominal vector.
  - Required: identical e/work_in; en fires 2 cycles after the last accepted byte.
- Async reset:
  - Stimulus: rst_n pulsed low after byte 50, asynchronous to clk.
  - Required: outputs go to 0 immediately and no en is produced.
  - Required: a fresh 64-byte frame afterwards produces correct results.

Source files
------------

// File: rtl/x25519_input_loader.sv
// Byte-serial RFC 7748 request loader: assembles scalar and u-coordinate,
// clamps/masks/reduces them and hands both to the X25519 main loop.
module x25519_input_loader #(
  parameter bit CLAMP    = 1'b1,
  parameter bit REDUCE_U = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic [7:0]   din,
  input  logic         din_last,
  input  logic         loop_done,
  output logic         en,
  output logic [255:0] e,
  output logic [255:0] work_in,
  output logic         busy,
  output logic         frame_err
);

  typedef enum logic [1:0] {LOAD_E, LOAD_U, FIRE, WAIT_DONE} state_t;

  localparam logic [255:0] P      = {1'b0, {250{1'b1}}, 5'b01101};
  localparam logic [255:0] U_MASK = {1'b0, {255{1'b1}}};

  state_t         state;
  logic   [5:0]   cnt;
  logic   [255:0] s_sh;
  logic   [255:0] u_sh;

  logic           accept;
  logic           byte_err;
  logic   [255:0] u_masked;
  logic   [256:0] u_diff;
  logic   [255:0] u_red;
  logic   [255:0] s_clamped;

  assign din_ready = (state == LOAD_E) || (state == LOAD_U);
  assign accept    = din_valid && din_ready;
  // Only byte 63 may (and must) carry din_last.
  assign byte_err  = (cnt == 6'd63) ? !din_last : din_last;

  // Borrow out of the 257-bit subtraction means the masked value is below p.
  assign u_masked  = u_sh & U_MASK;
  assign u_diff    = {1'b0, u_masked} - {1'b0, P};
  assign u_red     = (REDUCE_U && !u_diff[256]) ? u_diff[255:0] : u_masked;
  assign s_clamped = CLAMP ? {2'b01, s_sh[253:3], 3'b000} : s_sh;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD_E;
      cnt       <= '0;
      // NOTE: the wide shift registers are reset as well, so a frame aborted
      // by reset can never leak stale bytes into a later request.
      s_sh      <= '0;
      u_sh      <= '0;
      en        <= 1'b0;
      e         <= '0;
      work_in   <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      en        <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        LOAD_E, LOAD_U: begin
          if (accept) begin
            if (byte_err) begin
              frame_err <= 1'b1;
              busy      <= 1'b0;
              cnt       <= '0;
              s_sh      <= '0;
              u_sh      <= '0;
              state     <= LOAD_E;
            end else begin
              busy <= 1'b1;
              cnt  <= cnt + 6'd1;
              if (state == LOAD_E) begin
                s_sh <= {din, s_sh[255:8]};
                if (cnt == 6'd31) state <= LOAD_U;
              end else begin
                u_sh <= {din, u_sh[255:8]};
                if (cnt == 6'd63) state <= FIRE;
              end
            end
          end
        end
        FIRE: begin
          e       <= s_clamped;
          work_in <= u_red;
          en      <= 1'b1;
          cnt     <= '0;
          state   <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // A completion seen while the start pulse is still high is stale.
          if (loop_done && !en) begin
            state <= LOAD_E;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        end
        default: state <= LOAD_E;
      endcase
    end
  end

endmodule
